// File: rtl/regfile_writeback_queue.sv
// In-order write-back queue feeding the register file write port, with a
// pending-write scoreboard and youngest-value forwarding for two read ports.
//
// occupancy   | meaning
// ------------|-----------------------------------------------
// OCC_EMPTY   | count == 0: accepting, nothing to retire
// OCC_PARTIAL | 0 < count < DEPTH: accept and/or retire
// OCC_FULL    | count == DEPTH: not accepting, retire only
module regfile_writeback_queue #(
    parameter int DEPTH = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        wb_valid,
    input  logic [3:0]  wb_rd,
    input  logic [31:0] wb_data,
    output logic        wb_ready,
    input  logic        wb_hold,
    output logic [3:0]  Rd,
    output logic [31:0] write_value,
    output logic        regwrite,
    input  logic [3:0]  Rs,
    input  logic [3:0]  Rt,
    output logic        rs_pending,
    output logic        rt_pending,
    output logic [31:0] rs_fwd_data,
    output logic [31:0] rt_fwd_data,
    output logic        wb_empty
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    typedef enum logic [1:0] {
        OCC_EMPTY,
        OCC_PARTIAL,
        OCC_FULL
    } occ_t;

    occ_t             occ;
    logic [3:0]       mem_rd   [DEPTH];
    logic [31:0]      mem_data [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [CNT_W-1:0] count;
    logic             push;
    logic             pop;
    logic [32:0]      rs_hit;
    logic [32:0]      rt_hit;

    always_comb begin
        occ = OCC_PARTIAL;
        if (count == '0)
            occ = OCC_EMPTY;
        else if (count == CNT_W'(DEPTH))
            occ = OCC_FULL;
    end

    assign wb_ready = (occ != OCC_FULL);
    assign wb_empty = (occ == OCC_EMPTY) && !regwrite;
    // Writes to r0 complete the handshake but are dropped here.
    assign push     = wb_valid && wb_ready && (wb_rd != 4'd0);
    assign pop      = (occ != OCC_EMPTY) && !wb_hold;

    always_ff @(posedge clk) begin
        if (push) begin
            mem_rd[wr_ptr]   <= wb_rd;
            mem_data[wr_ptr] <= wb_data;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr      <= '0;
            rd_ptr      <= '0;
            count       <= '0;
            regwrite    <= 1'b0;
            Rd          <= 4'd0;
            write_value <= 32'd0;
        end else begin
            if (push)
                wr_ptr <= wr_ptr + 1'b1;
            if (pop) begin
                rd_ptr      <= rd_ptr + 1'b1;
                Rd          <= mem_rd[rd_ptr];
                write_value <= mem_data[rd_ptr];
                regwrite    <= 1'b1;
            end else begin
                regwrite    <= 1'b0;
            end
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // Walk oldest to youngest so the newest matching entry wins; the
    // output stage is older than every queued entry.
    function automatic logic [32:0] lookup(input logic [3:0] addr);
        logic [32:0]      r;
        logic [PTR_W-1:0] idx;
        r = '0;
        if (addr != 4'd0) begin
            if (regwrite && (Rd == addr))
                r = {1'b1, write_value};
            for (int i = 0; i < DEPTH; i++) begin
                idx = rd_ptr + PTR_W'(i);
                if ((CNT_W'(i) < count) && (mem_rd[idx] == addr))
                    r = {1'b1, mem_data[idx]};
            end
        end
        return r;
    endfunction

    always_comb begin
        rs_hit = lookup(Rs);
        rt_hit = lookup(Rt);
    end

    assign rs_pending  = rs_hit[32];
    assign rs_fwd_data = rs_hit[31:0];
    assign rt_pending  = rt_hit[32];
    assign rt_fwd_data = rt_hit[31:0];

endmodule

// File: doc/regfile_writeback_queue.md
# regfile_writeback_queue

Buffered write-side driver for the 16×32 register file in the multi-cycle CPU. It accepts register write results from the ALU/memory stages over a valid/ready handshake and queues them in a small in-order FIFO. It retires at most one entry per cycle onto the register file write port (`Rd`, `write_value`, `regwrite`). It also exposes a pending-write scoreboard with youngest-value forwarding for the two read-port addresses, so the control FSM can stall or bypass on RAW hazards.

## Interface
- `DEPTH`, 4: FIFO entries; power of two, ≥2.
- `clk` input 1: single clock; all state updates on the rising edge.
- `reset` input 1: asynchronous, active-low; low clears all state immediately.
- `wb_valid` input 1: producer offers a write this cycle.
- `wb_rd` input 4: destination register of the offered write.
- `wb_data` input 32: value of the offered write.
- `wb_ready` output 1: queue can accept; equals !full, from registered count.
- `wb_hold` input 1: high blocks retirement (e.g. memory stage owns the port).
- `Rd` output 4: register file write address.
- `write_value` output 32: register file write data.
- `regwrite` output 1: register file write enable; one cycle per retired entry.
- `Rs`, `Rt` input 4 each: read addresses being queried.
- `rs_pending`, `rt_pending` output 1 each: a write to that address is queued or on the port.
- `rs_fwd_data`, `rt_fwd_data` output 32 each: youngest pending value for that address; 0 when not pending.
- `wb_empty` output 1: FIFO empty and `regwrite` low.

## Operation
- Storage: DEPTH entries of {rd[3:0], data[31:0]}. Read and write pointers are log2(DEPTH) bits and wrap modulo DEPTH. `count` is log2(DEPTH)+1 bits.
- Enqueue fires when `wb_valid && wb_ready` at a clock edge.
  - If `wb_rd == 0`, the handshake completes but nothing is stored. Register 0 is never written.
- Output stage is a register holding {`Rd`, `write_value`, `regwrite`}.
  - Each edge with FIFO non-empty and `wb_hold` low: pop the head into the output stage and set `regwrite`=1.
  - Otherwise `regwrite` goes to 0. `Rd`/`write_value` hold their last value.
- Simultaneous enqueue and pop: allowed whenever not full; count is unchanged. When full, `wb_ready`=0 for that cycle even if a pop occurs.
- Scoreboard and forwarding are combinational over the valid FIFO entries plus the output stage when `regwrite`=1.
  - Priority is youngest first: newest FIFO entry, then older entries, then the output stage.
  - A write being offered this cycle is not visible until it is stored.
  - Query address 0 always gives pending=0 and data=0.
- State machine is implicit in `count` with three conditions:
  - EMPTY (count=0): `wb_ready`=1, no pop.
  - PARTIAL: enqueue and/or pop.
  - FULL (count=DEPTH): `wb_ready`=0, pop only.
  - Transitions follow count ±1 per edge.
- Reset (async, low), including mid-operation:
  - Clears pointers, count, `regwrite`, `Rd`, and `write_value` to 0.
  - Queued entries are discarded. `wb_ready`=1, `wb_empty`=1, all pending flags 0, all fwd data 0.

## Timing
- Latency from accept to `regwrite`:
  - Entry accepted at edge E into an empty queue, with hold low: popped at edge E+1, `regwrite`=1 for the cycle E+1..E+2.
  - Same-edge enqueue into an empty queue plus pop is not possible; the minimum latency is 1 cycle.
- Throughput: one retirement per cycle under continuous traffic with `wb_hold`=0.
- `wb_hold` is sampled at the edge.
  - Asserted at edge H: no pop at H, and `regwrite`=0 from H onward.
  - Resumes the cycle after hold falls.
- Pending flags cover an entry from the edge after acceptance through the cycle in which `regwrite` presents it. The register file performs the write during that cycle.
- `wb_ready`, `wb_empty`, and the scoreboard outputs depend only on registered state and `Rs`/`Rt`. There is no path from `wb_valid` to `wb_ready`.

## Test plan
- Single write, reset release:
  - Stimulus: wb_rd=5, data=0xDEADBEEF, valid for one cycle.
  - Response: `regwrite`=1, `Rd`=5, `write_value`=0xDEADBEEF exactly one cycle later, for one cycle. `rs_pending` with Rs=5 is high from the edge after acceptance until that cycle ends, then `wb_empty`=1.
- Fill to full with hold high:
  - Stimulus: 4 writes to r1..r4 (data 0x11..0x44), then a 5th offer to r6.
  - Response: `wb_ready`=0 and r6 is not accepted. After hold is released, four consecutive `regwrite` pulses appear in order r1..r4, then r6 retires.
- Forwarding priority:
  - Stimulus: with hold high, queue r3=0xA then r3=0xB; set Rs=3, Rt=0.
  - Response: `rs_pending`=1, `rs_fwd_data`=0xB; `rt_pending`=0, `rt_fwd_data`=0. After the first pop `rs_fwd_data` stays 0xB. After both retire, `rs_pending`=0.
- r0 filter:
  - Stimulus: offer wb_rd=0, data=0x1234.
  - Response: the handshake completes, no `regwrite` pulse follows, `wb_empty` stays 1.
- Simultaneous enqueue and pop with wrap-around:
  - Stimulus: stream 10 back-to-back writes (r1..r10, data=index) with hold low.
  - Response: 10 `regwrite` pulses in order, each 1 cycle after acceptance, and `wb_ready` never drops.
- Async reset mid-operation:
  - Stimulus: with 3 entries queued and `regwrite` high, drive reset low between edges.
  - Response: `regwrite`=0, `Rd`=0, `write_value`=0, `wb_ready`=1, `wb_empty`=1, pending flags 0 immediately. No retirement occurs after reset releases.
